// File: rtl/conv3d_stream_v2.sv
// Streaming 3D valid-mode correlation: one unsigned voxel per cycle in raster order,
// signed KxKxK kernel latched per frame, single registered output with backpressure.
module conv3d_stream_v2 #(
    parameter int K      = 3,
    parameter int D      = 8,
    parameter int H      = 64,
    parameter int W      = 64,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    localparam int ACC_W = DATA_W + COEF_W + $clog2(K*K*K) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          voxel_in,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic                       last_in,
    input  logic [K*K*K*COEF_W-1:0]    kernel,
    input  logic                       relu_en,
    output logic [ACC_W-1:0]           voxel_out,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic                       done,
    output logic                       err
);
    localparam int KN = K*K*K;
    localparam int L  = (K-1)*H*W + (K-1)*W + K;
    localparam int LS = (L > 1) ? L - 1 : 1;
    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam int ZW = (D > 1) ? $clog2(D) : 1;

    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic        [DATA_W-1:0] d,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [ACC_W-1:0] de;
        logic signed [ACC_W-1:0] ce;
        de = $signed({{(ACC_W-DATA_W){1'b0}}, d});
        ce = $signed({{(ACC_W-COEF_W){c[COEF_W-1]}}, c});
        return de * ce;
    endfunction

    function automatic logic signed [ACC_W-1:0] relu_clamp(
        input logic signed [ACC_W-1:0] s,
        input logic                    en
    );
        return (en && (s < 0)) ? '0 : s;
    endfunction

    logic [XW-1:0]             x_p0;
    logic [YW-1:0]             y_p0;
    logic [ZW-1:0]             z_p0;
    logic                      accept;
    logic                      first_vox;
    logic                      last_vox;
    logic                      out_cond;
    logic [KN*COEF_W-1:0]      kern_q;
    logic                      relu_q;
    logic [KN*COEF_W-1:0]      kern_eff;
    logic                      relu_eff;
    logic [LS*DATA_W-1:0]      line_p0;
    logic [DATA_W-1:0]         tap_p0 [KN];
    logic signed [ACC_W-1:0]   sum_p0;
    logic signed [ACC_W-1:0]   acc_p1;
    logic                      vld_p1;
    logic                      done_p1;
    logic                      err_q;

    assign ready_in  = !vld_p1 || ready_out;
    assign accept    = valid_in && ready_in;
    assign first_vox = (x_p0 == '0) && (y_p0 == '0) && (z_p0 == '0);
    assign last_vox  = (x_p0 == XW'(W-1)) && (y_p0 == YW'(H-1)) && (z_p0 == ZW'(D-1));
    assign out_cond  = (x_p0 >= XW'(K-1)) && (y_p0 >= YW'(K-1)) && (z_p0 >= ZW'(K-1));

    // Stage p0: raster counters, frame-length checking, kernel latch, window taps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p0  <= '0;
            y_p0  <= '0;
            z_p0  <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            if (last_in != last_vox)
                err_q <= 1'b1;
            if (x_p0 == XW'(W-1)) begin
                x_p0 <= '0;
                if (y_p0 == YW'(H-1)) begin
                    y_p0 <= '0;
                    z_p0 <= (z_p0 == ZW'(D-1)) ? '0 : z_p0 + ZW'(1);
                end else begin
                    y_p0 <= y_p0 + YW'(1);
                end
            end else begin
                x_p0 <= x_p0 + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && first_vox) begin
            kern_q <= kernel;
            relu_q <= relu_en;
        end
    end

    // The first voxel of a frame already sees the incoming kernel (matters only for K=1)
    assign kern_eff = first_vox ? kernel  : kern_q;
    assign relu_eff = first_vox ? relu_en : relu_q;

    generate
        if (L > 1) begin : g_line
            always_ff @(posedge clk) begin
                if (accept)
                    line_p0 <= {line_p0[(LS-1)*DATA_W-1:0], voxel_in};
            end
        end else begin : g_noline
            assign line_p0 = '0;
        end

        // Offset of each tap back from the voxel being accepted; slot 0 of the line is offset 1
        for (genvar k = 0; k < KN; k++) begin : g_tap
            localparam int DX  = k % K;
            localparam int DY  = (k / K) % K;
            localparam int DZ  = k / (K*K);
            localparam int OFF = (K-1-DX) + (K-1-DY)*W + (K-1-DZ)*H*W;
            if (OFF == 0) begin : g_cur
                assign tap_p0[k] = voxel_in;
            end else begin : g_old
                assign tap_p0[k] = line_p0[(OFF-1)*DATA_W +: DATA_W];
            end
        end
    endgenerate

    always_comb begin
        sum_p0 = '0;
        for (int k = 0; k < KN; k++)
            sum_p0 = sum_p0 + mac_term(tap_p0[k], $signed(kern_eff[k*COEF_W +: COEF_W]));
    end

    // Stage p1: single output register, reloads when drained in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1  <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1  <= out_cond;
            done_p1 <= last_vox;
            if (out_cond)
                acc_p1 <= relu_clamp(sum_p0, relu_eff);
        end else if (ready_out) begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end
    end

    assign voxel_out = acc_p1;
    assign valid_out = vld_p1;
    assign done      = done_p1;
    assign err       = err_q;

endmodule

// File: tb/tb_conv3d_stream_v2.sv
// Directed scoreboard bench for conv3d_stream_v2 on a 4x4x4 volume with a 3x3x3 kernel.
module tb_conv3d_stream_v2;
    localparam int K      = 3;
    localparam int D      = 4;
    localparam int H      = 4;
    localparam int W      = 4;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(K*K*K) + 1;
    localparam int KN     = K*K*K;
    localparam int N      = D*H*W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [DATA_W-1:0]       voxel_in;
    logic                    valid_in;
    logic                    ready_in;
    logic                    last_in;
    logic [KN*COEF_W-1:0]    kernel;
    logic                    relu_en;
    logic [ACC_W-1:0]        voxel_out;
    logic                    valid_out;
    logic                    ready_out;
    logic                    done;
    logic                    err;

    conv3d_stream_v2 #(.K(K), .D(D), .H(H), .W(W), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
        .clk(clk), .rst_n(rst_n), .voxel_in(voxel_in), .valid_in(valid_in), .ready_in(ready_in),
        .last_in(last_in), .kernel(kernel), .relu_en(relu_en), .voxel_out(voxel_out),
        .valid_out(valid_out), .ready_out(ready_out), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        bit     last;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_tab [8];
    bit     stall_mode = 1'b0;
    logic [KN*COEF_W-1:0] kernel_alt;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [KN*COEF_W-1:0] fill(input int c);
        logic [KN*COEF_W-1:0] v;
        for (int k = 0; k < KN; k++) v[k*COEF_W +: COEF_W] = COEF_W'(c);
        return v;
    endfunction

    function automatic logic [KN*COEF_W-1:0] centre_only();
        logic [KN*COEF_W-1:0] v;
        v = '0;
        v[13*COEF_W +: COEF_W] = 8'd1;
        return v;
    endfunction

    task automatic set_exp_const(input longint v);
        for (int j = 0; j < 8; j++) exp_tab[j] = v;
    endtask

    task automatic set_exp_ramp();
        exp_tab[0] = 21; exp_tab[1] = 22; exp_tab[2] = 25; exp_tab[3] = 26;
        exp_tab[4] = 37; exp_tab[5] = 38; exp_tab[6] = 41; exp_tab[7] = 42;
    endtask

    task automatic pop_cmp();
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got value %0d with no beat expected", $signed(voxel_out));
        end else begin
            e = sb.pop_front();
            n_checks--;
            check("beat_value", $signed(voxel_out), e.val);
            check("beat_done", longint'(done), longint'(e.last));
        end
    endtask

    // Output monitor: pops one expectation per output transfer, optionally stalls every other beat
    initial begin : monitor
        int     left;
        bit     stall_next;
        longint held;
        left       = 0;
        stall_next = 1'b0;
        held       = 0;
        ready_out  = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && valid_out) begin
                if (!ready_out) begin
                    check("stall_hold", $signed(voxel_out), held);
                    check("stall_ready_in", longint'(ready_in), 0);
                    left--;
                    if (left == 0) begin
                        ready_out = 1'b1;
                        pop_cmp();
                    end
                end else if (stall_mode && stall_next) begin
                    stall_next = 1'b0;
                    held       = $signed(voxel_out);
                    ready_out  = 1'b0;
                    left       = 3;
                end else begin
                    pop_cmp();
                    if (stall_mode) stall_next = 1'b1;
                end
            end
        end
    end

    task automatic summary_and_finish();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic wait_accept(output bit ok);
        bit rdy;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #7;
            rdy = ready_in;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic send_frame(input bit ramp, input logic [7:0] cval, input int last_at,
                              input int stop_at, input bit kmid, input bit lat_chk);
        int oi;
        bit ok;
        oi = 0;
        for (int i = 0; i < N; i++) begin
            voxel_in = ramp ? 8'(i) : cval;
            last_in  = (i == last_at);
            valid_in = 1'b1;
            wait_accept(ok);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: voxel %0d not accepted within 200 cycles", i);
                summary_and_finish();
            end
            if (kmid && i == 0) kernel = kernel_alt;
            if (lat_chk && i == 41) check("latency_before", longint'(valid_out), 0);
            if (lat_chk && i == 42) check("latency_first", longint'(valid_out), 1);
            if ((i % W) >= K-1 && ((i / W) % H) >= K-1 && (i / (W*H)) >= K-1) begin
                sb.push_back(exp_t'{exp_tab[oi], (i == N-1)});
                oi++;
            end
            if (i == stop_at) begin
                valid_in = 1'b0;
                last_in  = 1'b0;
                return;
            end
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_n      = 1'b0;
        voxel_in   = '0;
        valid_in   = 1'b0;
        last_in    = 1'b0;
        kernel     = '0;
        kernel_alt = '0;
        relu_en    = 1'b0;
        #2;
        check("reset_voxel_out", longint'(voxel_out), 0);
        check("reset_valid_out", longint'(valid_out), 0);
        check("reset_done", longint'(done), 0);
        check("reset_err", longint'(err), 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", longint'(ready_in), 1);

        // All ones, all coefficients one
        kernel = fill(1);
        set_exp_const(27);
        send_frame(1'b0, 8'd1, N-1, -1, 1'b0, 1'b1);
        drain();
        check("err_clean_frame", longint'(err), 0);

        // Ramp with centre tap only
        kernel = centre_only();
        set_exp_ramp();
        send_frame(1'b1, 8'd0, N-1, -1, 1'b0, 1'b0);
        drain();

        // Negative coefficients, with and without ReLU
        kernel  = fill(-1);
        relu_en = 1'b0;
        set_exp_const(-54);
        send_frame(1'b0, 8'd2, N-1, -1, 1'b0, 1'b0);
        drain();
        relu_en = 1'b1;
        set_exp_const(0);
        send_frame(1'b0, 8'd2, N-1, -1, 1'b0, 1'b0);
        drain();
        relu_en = 1'b0;

        // Backpressure: stall every other beat for three cycles
        stall_mode = 1'b1;
        kernel     = centre_only();
        set_exp_ramp();
        send_frame(1'b1, 8'd0, N-1, -1, 1'b0, 1'b0);
        drain();
        stall_mode = 1'b0;

        // Early last_in plus a mid-frame kernel change
        kernel     = fill(1);
        kernel_alt = fill(2);
        set_exp_const(27);
        send_frame(1'b0, 8'd1, 30, -1, 1'b1, 1'b0);
        drain();
        check("err_set", longint'(err), 1);

        // Reset in the middle of a frame
        kernel = centre_only();
        set_exp_ramp();
        send_frame(1'b1, 8'd0, N-1, 50, 1'b0, 1'b0);
        check("err_sticky", longint'(err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid_out", longint'(valid_out), 0);
        check("midreset_done", longint'(done), 0);
        check("midreset_err", longint'(err), 0);
        check("midreset_voxel_out", longint'(voxel_out), 0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(1'b1, 8'd0, N-1, -1, 1'b0, 1'b0);
        drain();
        check("err_after_reset", longint'(err), 0);

        summary_and_finish();
    end

endmodule
